// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared data-memory / MIO port.
// Master 0 is the CPU memory interface, master 1 a secondary requester.
// Each transfer: one IDLE arbitration cycle, LAT ACCESS cycles, one DONE cycle
// carrying the completion pulse back to the granted master.
module mem_bus_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2   // access cycles per transfer, 1..15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rdy,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rdy,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t     state;
    logic [3:0] count;
    logic       last_grant;
    logic       any_req;
    logic       winner;

    // Arbitration: a lone requester wins; on a tie the master that was not
    // served last wins, so continuous contention alternates 0,1,0,1.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last_grant;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    // Transfer sequencer: latch the winner's request, hold the port for LAT
    // cycles, capture read data on the last one, then pulse rdy for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_rdy     <= 1'b0;
            m1_rdy     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_rdy <= 1'b0;
            m1_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        busy       <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_we     <= winner ? m1_we : m0_we;
                        mem_addr   <= winner ? m1_addr : m0_addr;
                        mem_wdata  <= winner ? m1_wdata : m0_wdata;
                        count      <= LAT_M1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        // mem_we still holds the transfer direction here
                        if (!mem_we) begin
                            if (grant) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                        if (grant) m1_rdy <= 1'b1;
                        else       m0_rdy <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a LAT=2 and a LAT=1 instance driven by random
// masters, checked every cycle against a transaction-timeline model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        req     [2][2];
    logic        we_in   [2][2];
    logic [31:0] addr_in [2][2];
    logic [31:0] wd_in   [2][2];
    logic        rdy     [2][2];
    logic [31:0] rdata   [2][2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
    logic        grant     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .LAT(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .m0_req(req[0][0]), .m0_we(we_in[0][0]), .m0_addr(addr_in[0][0]), .m0_wdata(wd_in[0][0]),
        .m0_rdy(rdy[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we_in[0][1]), .m1_addr(addr_in[0][1]), .m1_wdata(wd_in[0][1]),
        .m1_rdy(rdy[0][1]), .m1_rdata(rdata[0][1]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant(grant[0])
    );

    mem_bus_arbiter #(.AW(32), .DW(32), .LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .m0_req(req[1][0]), .m0_we(we_in[1][0]), .m0_addr(addr_in[1][0]), .m0_wdata(wd_in[1][0]),
        .m0_rdy(rdy[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we_in[1][1]), .m1_addr(addr_in[1][1]), .m1_wdata(wd_in[1][1]),
        .m1_rdy(rdy[1][1]), .m1_rdata(rdata[1][1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant(grant[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 | i);
    endfunction

    // Memory behind each port: 16 words indexed by addr[5:2].
    logic [31:0] bmem [2][16];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                if (reset)
                    bmem[d][i] <= init_word(i);
                else if (mem_en[d] && mem_we[d] && mem_addr[d][5:2] == i[3:0])
                    bmem[d][i] <= mem_wdata[d];
            end
        end
    end

    assign mem_rdata[0] = mem_en[0] ? bmem[0][mem_addr[0][5:2]] : 32'hFFFF_0000;
    assign mem_rdata[1] = mem_en[1] ? bmem[1][mem_addr[1][5:2]] : 32'hFFFF_0001;

    // Reference model: transaction timeline per instance.
    int          cyc = 0;
    bit          active   [2];
    int          start    [2];
    int          win      [2];
    bit          t_we     [2];
    logic [31:0] t_addr   [2];
    logic [31:0] t_wd     [2];
    logic [31:0] la_addr  [2];
    logic [31:0] la_wd    [2];
    int          next_arb [2];
    int          m_last   [2];
    int          g_exp    [2];
    logic [31:0] exp_rd   [2][2];
    logic [31:0] ref_mem  [2][16];

    // Master drivers.
    bit          pend   [2][2];
    int          idle   [2][2];
    bit          dir_v  [2][2];
    bit          dir_we [2][2];
    logic [31:0] dir_a  [2][2];
    logic [31:0] dir_d  [2][2];
    bit          auto_en  = 1'b0;
    bit          hog      = 1'b0;
    bit          drops_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            active[d]   = 1'b0;
            next_arb[d] = 0;
            m_last[d]   = 1;
            g_exp[d]    = 0;
            la_addr[d]  = '0;
            la_wd[d]    = '0;
            for (int i = 0; i < 16; i++) ref_mem[d][i] = init_word(i);
            for (int m = 0; m < 2; m++) begin
                exp_rd[d][m]  = '0;
                pend[d][m]    = 1'b0;
                idle[d][m]    = 0;
                req[d][m]     = 1'b0;
                we_in[d][m]   = 1'b0;
                addr_in[d][m] = '0;
                wd_in[d][m]   = '0;
            end
        end
    endtask

    task automatic set_dir(input int d, input int m, input bit w, input logic [31:0] a, input logic [31:0] wd);
        dir_v[d][m]  = 1'b1;
        dir_we[d][m] = w;
        dir_a[d][m]  = a;
        dir_d[d][m]  = wd;
    endtask

    // One clock: check outputs seen at the falling edge, move the masters,
    // then let the model arbitrate on what the next rising edge will sample.
    task automatic cycle(input bit rst);
        int L, rel, w;
        bit exp_en, exp_done, r0, r1;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            L        = lat_of(d);
            rel      = cyc - start[d];
            exp_en   = active[d] && rel >= 1 && rel <= L;
            exp_done = active[d] && rel == L + 1;
            if (exp_done) begin
                if (t_we[d]) ref_mem[d][t_addr[d][5:2]] = t_wd[d];
                else         exp_rd[d][win[d]] = ref_mem[d][t_addr[d][5:2]];
            end
            check($sformatf("d%0d_mem_en", d), mem_en[d], exp_en);
            check($sformatf("d%0d_mem_we", d), mem_we[d], exp_en && t_we[d]);
            check($sformatf("d%0d_mem_addr", d), mem_addr[d], la_addr[d]);
            check($sformatf("d%0d_mem_wdata", d), mem_wdata[d], la_wd[d]);
            check($sformatf("d%0d_m0_rdy", d), rdy[d][0], exp_done && win[d] == 0);
            check($sformatf("d%0d_m1_rdy", d), rdy[d][1], exp_done && win[d] == 1);
            check($sformatf("d%0d_busy", d), busy[d], exp_en || exp_done);
            check($sformatf("d%0d_grant", d), grant[d], g_exp[d]);
            check($sformatf("d%0d_m0_rdata", d), rdata[d][0], exp_rd[d][0]);
            check($sformatf("d%0d_m1_rdata", d), rdata[d][1], exp_rd[d][1]);
            if (exp_done) begin
                active[d]   = 1'b0;
                next_arb[d] = start[d] + L + 2;
            end
            for (int m = 0; m < 2; m++) begin
                if (pend[d][m] && exp_done && win[d] == m) begin
                    pend[d][m] = 1'b0;
                    req[d][m]  = 1'b0;
                    idle[d][m] = hog ? 0 : int'($urandom_range(0, 4));
                end else if (pend[d][m] && exp_en && win[d] == m) begin
                    // after the grant the inputs must be ignored
                    addr_in[d][m] = $urandom;
                    wd_in[d][m]   = $urandom;
                    we_in[d][m]   = ~we_in[d][m];
                    if (drops_en && $urandom_range(0, 3) == 0) req[d][m] = 1'b0;
                end else if (!pend[d][m]) begin
                    if (dir_v[d][m]) begin
                        dir_v[d][m]   = 1'b0;
                        pend[d][m]    = 1'b1;
                        req[d][m]     = 1'b1;
                        we_in[d][m]   = dir_we[d][m];
                        addr_in[d][m] = dir_a[d][m];
                        wd_in[d][m]   = dir_d[d][m];
                    end else if (auto_en) begin
                        if (idle[d][m] == 0) begin
                            pend[d][m]    = 1'b1;
                            req[d][m]     = 1'b1;
                            we_in[d][m]   = 1'($urandom_range(0, 1));
                            addr_in[d][m] = $urandom;
                            wd_in[d][m]   = $urandom;
                        end else begin
                            idle[d][m]--;
                        end
                    end
                end
            end
            r0 = req[d][0];
            r1 = req[d][1];
            if (!rst && !active[d] && cyc >= next_arb[d] && (r0 || r1)) begin
                w = (r0 && r1) ? 1 - m_last[d] : (r1 ? 1 : 0);
                active[d]  = 1'b1;
                start[d]   = cyc;
                win[d]     = w;
                m_last[d]  = w;
                g_exp[d]   = w;
                t_we[d]    = we_in[d][w];
                t_addr[d]  = addr_in[d][w];
                t_wd[d]    = wd_in[d][w];
                la_addr[d] = addr_in[d][w];
                la_wd[d]   = wd_in[d][w];
            end
        end
        if (rst) begin
            reset = 1'b1;
            model_reset();
        end else begin
            reset = 1'b0;
        end
    endtask

    initial begin
        bit found;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) dir_v[d][m] = 1'b0;
        model_reset();
        repeat (3) cycle(1'b1);

        // m0 read of 0x10 on both instances
        for (int d = 0; d < 2; d++) set_dir(d, 0, 1'b0, 32'h0000_0010, 32'h0);
        repeat (8) cycle(1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_plan_m0_read", d), rdata[d][0], 32'hDEADBEEF);

        // m1 write of 0x12345678 to 0x20, then m0 reads it back
        for (int d = 0; d < 2; d++) set_dir(d, 1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        repeat (8) cycle(1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_plan_m1_wr_rdata", d), rdata[d][1], 32'h0);
        for (int d = 0; d < 2; d++) set_dir(d, 0, 1'b0, 32'h0000_0020, 32'h0);
        repeat (8) cycle(1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_plan_readback", d), rdata[d][0], 32'h1234_5678);

        // both masters requesting continuously from reset
        repeat (2) cycle(1'b1);
        hog     = 1'b1;
        auto_en = 1'b1;
        repeat (30) cycle(1'b0);

        // random traffic with mid-transfer request drops
        hog      = 1'b0;
        drops_en = 1'b1;
        repeat (1500) cycle(1'b0);

        // let outstanding transfers finish
        auto_en  = 1'b0;
        drops_en = 1'b0;
        repeat (12) cycle(1'b0);

        // reset during the second ACCESS cycle of the LAT=2 instance
        set_dir(0, 0, 1'b0, 32'h0000_0010, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b0);
            if (active[0] && cyc - start[0] == 1) found = 1'b1;
        end
        if (!found) check("rst_wait_timeout", 32'd0, 32'd1);
        cycle(1'b1);
        for (int d = 0; d < 2; d++) begin
            set_dir(d, 0, 1'b0, 32'h0000_0010, 32'h0);
            set_dir(d, 1, 1'b0, 32'h0000_0024, 32'h0);
        end
        cycle(1'b0);
        cycle(1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("d%0d_tie_after_reset", d), grant[d], 32'd0);
        repeat (12) cycle(1'b0);
        check("d0_post_reset_m0_read", rdata[0][0], 32'hDEADBEEF);
        check("d0_post_reset_m1_read", rdata[0][1], 32'h5A00_0009);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
